// File: rtl/inst_sram_axi_bridge_pkg.sv
// Shared AXI read-channel constants and SRAM-like size encodings for the instruction bridge.
package inst_sram_axi_bridge_pkg;

    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    localparam logic [2:0] AXI_SIZE_1B  = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B  = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B  = 3'b010;

    localparam logic [1:0] SRAM_SIZE_1B = 2'd0;
    localparam logic [1:0] SRAM_SIZE_2B = 2'd1;
    localparam logic [1:0] SRAM_SIZE_4B = 2'd2;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_e;

    function automatic logic [2:0] to_axi_size(input logic [1:0] size);
        case (size)
            SRAM_SIZE_1B: return AXI_SIZE_1B;
            SRAM_SIZE_2B: return AXI_SIZE_2B;
            SRAM_SIZE_4B: return AXI_SIZE_4B;
            default:      return {1'b0, size};
        endcase
    endfunction

endpackage

// File: rtl/inst_sram_axi_bridge.sv
// SRAM-like instruction port to AXI4 read-only master; single-beat reads, in-order,
// up to MAX_OUTSTANDING in flight, with registered read data back to fetch.
module inst_sram_axi_bridge
    import inst_sram_axi_bridge_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  AXI_ID          = 4'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bridge_err
);

    localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    ar_state_e        state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      araddr_q;
    logic [1:0]       size_q;
    logic [31:0]      rdata_q;
    logic             data_ok_q;
    logic             err_q;
    logic             accept;
    logic             r_fire;
    logic             unused_inputs;

    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

    always_ff @(posedge clk) begin
        if (!resetn) state <= AR_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            AR_IDLE: if (accept)  state_next = AR_SEND;
            AR_SEND: if (arready) state_next = AR_IDLE;
            default:              state_next = AR_IDLE;
        endcase
    end

    always_comb begin
        accept  = 1'b0;
        arvalid = 1'b0;
        case (state)
            AR_IDLE: accept  = inst_sram_req && !inst_sram_wr && (cnt < CNT_MAX);
            AR_SEND: arvalid = 1'b1;
            default: ;
        endcase
    end

    // Only accept R beats while a read is outstanding, so the count can never underflow.
    assign rready = (cnt != '0);
    assign r_fire = rvalid && rready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            araddr_q  <= '0;
            size_q    <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                araddr_q <= inst_sram_addr;
                size_q   <= inst_sram_size;
            end
            case ({accept, r_fire})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
            data_ok_q <= r_fire;
            if (r_fire) begin
                rdata_q <= rdata;
                if (rresp != RESP_OKAY) err_q <= 1'b1;
            end
        end
    end

    assign inst_sram_addr_ok = accept;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;
    assign bridge_err        = err_q;

    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arlen   = '0;
    assign arsize  = to_axi_size(size_q);
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    r_beat_while_idle: assert property (@(posedge clk) disable iff (!resetn)
        !(rvalid && cnt == '0));

    cnt_in_range: assert property (@(posedge clk) disable iff (!resetn)
        cnt <= CNT_MAX);

endmodule

// File: doc/inst_sram_axi_bridge.md
Name: inst_sram_axi_bridge

Overview:
- Upstream neighbour of the fetch stage; services its SRAM-like instruction port (req / addr_ok / data_ok) over an AXI4 read-only master (AR/R channels).
- Accepts up to MAX_OUTSTANDING in-flight reads, issues them as single-beat AXI reads, and returns data in request order.
- Registered responses keep AXI R paths out of the fetch stage's combinational logic.

Parameters:
- MAX_OUTSTANDING, 2, max accepted-but-unanswered reads (1..4)
- AXI_ID, 4'h0, constant arid for all fetch reads

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous active-low reset
- inst_sram_req  in  1  fetch request valid
- inst_sram_wr  in  1  write flag; must be 0
- inst_sram_size  in  2  0:1B 1:2B 2:4B
- inst_sram_addr  in  32  byte address
- inst_sram_wstrb  in  4  unused
- inst_sram_wdata  in  32  unused
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  read data valid this cycle
- inst_sram_rdata  out  32  read data
- arid  out  4  =AXI_ID
- araddr  out  32  read address
- arlen  out  8  =0
- arsize  out  3  {1'b0, size}
- arburst  out  2  =2'b01
- arlock  out  2  =0
- arcache  out  4  =0
- arprot  out  3  =0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  ignored (single ID, in-order)
- rdata  in  32  read data
- rresp  in  2  response code
- rlast  in  1  ignored (single beat)
- rvalid  in  1  R valid
- rready  out  1  R ready
- bridge_err  out  1  sticky: rresp != OKAY seen

Behaviour:
- Reset (resetn=0 at posedge): AR FSM to AR_IDLE, arvalid=0, araddr=0, arsize=0, outstanding count=0, data_ok=0, rdata reg=0, bridge_err=0. Reset mid-transaction drops all in-flight state; the interconnect is reset in the same cycle.
- AR FSM:
  - AR_IDLE: addr_ok = req && !wr && cnt < MAX_OUTSTANDING, combinational from req. On addr_ok, latch addr and size into AR regs, go AR_SEND.
  - AR_SEND: arvalid=1 and addr_ok=0. AR regs are held stable until arready. On arvalid && arready, go AR_IDLE.
  - Minimum spacing between accepted requests: 2 cycles (accept, AR handshake).
- Outstanding counter, width $clog2(MAX_OUTSTANDING+1):
  - +1 on addr_ok; -1 on R handshake.
  - Simultaneous increment and decrement leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows. An R beat with cnt=0 is a protocol violation; flag it with an assertion only.
- R channel:
  - rready = (cnt != 0).
  - On rvalid && rready: capture rdata into the rdata reg and set data_ok=1 on the next cycle, for exactly one cycle.
  - Back-to-back R beats give back-to-back data_ok pulses.
  - Latency from R handshake to data_ok: 1 cycle. The fetch stage always consumes data_ok; there is no backpressure.
- rresp != 2'b00 on a handshake: data is still returned, and bridge_err sets and stays set until reset.
- inst_sram_wr=1 with req: never accepted (addr_ok=0, no AXI activity). The fetch stage ties wr to 0.
- inst_sram_rdata holds its value between data_ok pulses.
- req may drop without being accepted; nothing is latched in that case.

Decomposition:
- Shared package: AXI constants (BURST_INCR=2'b01, RESP_OKAY=2'b00, SIZE_1B/2B/4B) and the sram-like size encodings.
- Add MAX_OUTSTANDING to the mycpu.h parameter set.
- No sub-module needed. If the write path is added later, a separate inst/data arbiter wraps this block.

Test Plan:
- Single read: req, addr=0x1C000000, size=2, arready=1 immediately, rvalid two cycles later with rdata=0x02C00000 -> addr_ok at cycle 0, arvalid cycle 1 with araddr=0x1C000000 and arsize=3'b010, data_ok=1 with rdata=0x02C00000 one cycle after the R handshake.
- arready held low 5 cycles -> arvalid stays 1 and araddr stable; no second addr_ok until the AR handshake completes.
- Outstanding limit (MAX=2): three back-to-back reqs with R delayed -> two addr_ok, third stalls with cnt=2; first R beat -> cnt=1, third request accepted.
- Simultaneous accept and R handshake at cnt=1 -> cnt stays 1; data_ok pulses exactly once.
- rresp=2'b10 on one beat -> data_ok still asserted with the data; bridge_err=1 and stays set through later OKAY beats until resetn=0.
- resetn=0 while in AR_SEND with cnt=2 -> next cycle arvalid=0, cnt=0, data_ok=0, bridge_err=0.
